pipe_hazard_unit: RTL and testbench

Parametrised hazard, forwarding and bubble controller for the in-order RISC-V pipelines built on `Riscv151`. It tracks the destination register, write-enable and load flag of every in-flight instruction across `DEPTH` post-decode stages. Each cycle it decides, for the instruction in decode, one of three outcomes: it may issue, it needs a forwarding path for rs1/rs2, or it must hold for a load-use bubble. It also applies external stall and branch/jump flush uniformly, replacing the hand-wired per-stage flag buffers with one configurable block.

---
 rtl/pipe_hazard_pkg.sv | 17 +
 rtl/hazard_match.sv | 31 +++
 rtl/pipe_hazard_unit.sv | 110 +++++++++++
 tb/tb_pipe_hazard_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_pkg.sv
// Shared types and defaults for the pipeline hazard/forwarding controller.
package pipe_hazard_pkg;

  localparam int DEPTH_DEF      = 3;
  localparam int LOAD_STAGE_DEF = 3;
  localparam int KILL_DEPTH_DEF = 1;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       valid;
    logic       we;
    logic       is_load;
    logic [4:0] rd;
  } entry_t;

endpackage

// File: rtl/hazard_match.sv
// Per-source comparator and youngest-first priority encoder over the in-flight entries.
module hazard_match
  import pipe_hazard_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int SELW  = $clog2(DEPTH + 1)
) (
  input  entry_t [DEPTH-1:0] entries_i,
  input  logic [4:0]         src_i,
  input  logic               used_i,
  output logic               hit_o,
  output logic [SELW-1:0]    sel_o,
  output logic               is_load_o
);

  // Scan oldest to youngest so the youngest match is the last assignment.
  always_comb begin
    hit_o     = 1'b0;
    sel_o     = '0;
    is_load_o = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (used_i && entries_i[k].valid && entries_i[k].we &&
          entries_i[k].rd == src_i && entries_i[k].rd != REG_ZERO) begin
        hit_o     = 1'b1;
        sel_o     = SELW'(k + 1);
        is_load_o = entries_i[k].is_load;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and bubble controller for DEPTH post-decode stages.
// Optional performance counters are enabled with PIPE_HAZARD_PERF_EN.
module pipe_hazard_unit
  import pipe_hazard_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int LOAD_STAGE = LOAD_STAGE_DEF,
  parameter int KILL_DEPTH = KILL_DEPTH_DEF,
  parameter int SELW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             dec_valid,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_rs1_used,
  input  logic             dec_rs2_used,
  input  logic [4:0]       dec_rd,
  input  logic             dec_we,
  input  logic             dec_is_load,
  output logic             issue,
  output logic             dec_hold,
  output logic             bubble,
  output logic [SELW-1:0]  fwd_sel_a,
  output logic [SELW-1:0]  fwd_sel_b,
`ifdef PIPE_HAZARD_PERF_EN
  output logic [31:0]      perf_bubbles,
  output logic [31:0]      perf_flushes,
`endif
  output logic [DEPTH-1:0] stage_we
);

  localparam logic [SELW-1:0] LOAD_SEL = SELW'(LOAD_STAGE);

  entry_t [DEPTH-1:0] ent_q, ent_d;
  entry_t             dec_entry;
  logic               hit_a, hit_b, ld_a, ld_b;

  hazard_match #(.DEPTH(DEPTH), .SELW(SELW)) u_match_a (
    .entries_i (ent_q),
    .src_i     (dec_rs1),
    .used_i    (dec_rs1_used),
    .hit_o     (hit_a),
    .sel_o     (fwd_sel_a),
    .is_load_o (ld_a)
  );

  hazard_match #(.DEPTH(DEPTH), .SELW(SELW)) u_match_b (
    .entries_i (ent_q),
    .src_i     (dec_rs2),
    .used_i    (dec_rs2_used),
    .hit_o     (hit_b),
    .sel_o     (fwd_sel_b),
    .is_load_o (ld_b)
  );

  // A load is only forwardable once it reaches LOAD_STAGE.
  assign bubble   = dec_valid & ((hit_a & ld_a & (fwd_sel_a < LOAD_SEL)) |
                                 (hit_b & ld_b & (fwd_sel_b < LOAD_SEL)));
  assign issue    = dec_valid & ~bubble & ~stall & ~flush;
  assign dec_hold = stall | bubble;

  always_comb begin
    dec_entry         = '0;
    dec_entry.valid   = 1'b1;
    dec_entry.we      = dec_we;
    dec_entry.is_load = dec_is_load;
    dec_entry.rd      = dec_rd;
  end

  always_comb begin
    ent_d = ent_q;
    if (!stall) begin
      ent_d[0] = issue ? dec_entry : '0;
      for (int k = 1; k < DEPTH; k++) begin
        ent_d[k] = (flush && k <= KILL_DEPTH) ? '0 : ent_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ent_q <= '0;
    else        ent_q <= ent_d;
  end

  always_comb begin
    stage_we = '0;
    for (int k = 0; k < DEPTH; k++) stage_we[k] = ent_q[k].valid & ent_q[k].we;
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_bubbles_q, perf_flushes_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_bubbles_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      if (bubble & ~stall & ~flush) perf_bubbles_q <= perf_bubbles_q + 32'd1;
      if (flush & ~stall)           perf_flushes_q <= perf_flushes_q + 32'd1;
    end
  end

  assign perf_bubbles = perf_bubbles_q;
  assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench: in-flight instruction list model plus directed scenarios.
module tb_pipe_hazard_unit;

  localparam int D  = 3;
  localparam int LS = 3;
  localparam int KD = 1;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          reset, stall, flush, dec_valid;
  logic [4:0]    dec_rs1, dec_rs2, dec_rd;
  logic          dec_rs1_used, dec_rs2_used, dec_we, dec_is_load;
  logic          issue, dec_hold, bubble;
  logic [SW-1:0] fwd_sel_a, fwd_sel_b;
  logic [D-1:0]  stage_we;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0]   perf_bubbles, perf_flushes;
`endif

  pipe_hazard_unit #(.DEPTH(D), .LOAD_STAGE(LS), .KILL_DEPTH(KD), .SELW(SW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rs1_used(dec_rs1_used),
    .dec_rs2_used(dec_rs2_used), .dec_rd(dec_rd), .dec_we(dec_we),
    .dec_is_load(dec_is_load), .issue(issue), .dec_hold(dec_hold), .bubble(bubble),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
`ifdef PIPE_HAZARD_PERF_EN
    .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes),
`endif
    .stage_we(stage_we)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // In-flight instructions, index 1 = execute (youngest) .. D = writeback.
  bit         m_v  [1:D];
  bit         m_we [1:D];
  bit         m_ld [1:D];
  logic [4:0] m_rd [1:D];
  longint     m_pb, m_pf;

  task automatic chk(string nm, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 1; k <= D; k++) begin
      m_v[k] = 0; m_we[k] = 0; m_ld[k] = 0; m_rd[k] = '0;
    end
    m_pb = 0; m_pf = 0;
  endtask

  function automatic int find(logic [4:0] s, logic used, output bit ld);
    ld = 0;
    if (!used || s == 5'd0) return 0;
    for (int k = 1; k <= D; k++)
      if (m_v[k] && m_we[k] && m_rd[k] == s) begin
        ld = m_ld[k];
        return k;
      end
    return 0;
  endfunction

  task automatic model_outs(output int ea, output int eb, output bit ebub, output bit eiss,
                            output bit ehold, output int ewe);
    bit la, lb;
    ea    = find(dec_rs1, dec_rs1_used, la);
    eb    = find(dec_rs2, dec_rs2_used, lb);
    ebub  = dec_valid && ((ea != 0 && la && ea < LS) || (eb != 0 && lb && eb < LS));
    eiss  = dec_valid && !ebub && !stall && !flush;
    ehold = stall || ebub;
    ewe   = 0;
    for (int k = 1; k <= D; k++) if (m_v[k] && m_we[k]) ewe |= (1 << (k - 1));
  endtask

  task automatic check_all();
    int ea, eb, ewe;
    bit ebub, eiss, ehold;
    model_outs(ea, eb, ebub, eiss, ehold, ewe);
    chk("m_fwd_a", fwd_sel_a, ea);
    chk("m_fwd_b", fwd_sel_b, eb);
    chk("m_bubble", bubble, ebub);
    chk("m_issue", issue, eiss);
    chk("m_dec_hold", dec_hold, ehold);
    chk("m_stage_we", stage_we, ewe);
`ifdef PIPE_HAZARD_PERF_EN
    chk("m_perf_bubbles", perf_bubbles, m_pb);
    chk("m_perf_flushes", perf_flushes, m_pf);
`endif
  endtask

  task automatic model_update();
    int ea, eb, ewe;
    bit ebub, eiss, ehold;
    if (!reset) begin
      model_clear();
      return;
    end
    if (stall) return;
    model_outs(ea, eb, ebub, eiss, ehold, ewe);
    if (ebub && !flush) m_pb++;
    if (flush) m_pf++;
    for (int k = D; k >= 2; k--) begin
      m_v[k] = m_v[k-1]; m_we[k] = m_we[k-1]; m_ld[k] = m_ld[k-1]; m_rd[k] = m_rd[k-1];
    end
    m_v[1] = eiss; m_we[1] = dec_we; m_ld[1] = dec_is_load; m_rd[1] = dec_rd;
    if (flush) for (int k = 2; k <= KD + 1; k++) m_v[k] = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_dec(logic v, logic [4:0] r1, logic u1, logic [4:0] r2, logic u2,
                         logic [4:0] rd, logic we, logic ld);
    dec_valid = v; dec_rs1 = r1; dec_rs1_used = u1; dec_rs2 = r2; dec_rs2_used = u2;
    dec_rd = rd; dec_we = we; dec_is_load = ld;
    #1;
  endtask

  task automatic drain();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (D) tick();
  endtask

  initial begin
    model_clear();
    reset = 1'b0; stall = 1'b1; flush = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_issue", issue, 0);
    chk("rst_bubble", bubble, 0);
    chk("rst_dec_hold", dec_hold, 1);
    chk("rst_stage_we", stage_we, 0);
    tick();
    stall = 1'b0; reset = 1'b1;
    tick();

    // addi x5 then add x6,x5,x5
    set_dec(1, 0, 1, 0, 0, 5, 1, 0);
    chk("addi_issue", issue, 1);
    tick();
    set_dec(1, 5, 1, 5, 1, 6, 1, 0);
    chk("raw_fwd_a", fwd_sel_a, 1);
    chk("raw_fwd_b", fwd_sel_b, 1);
    chk("raw_bubble", bubble, 0);
    chk("raw_issue", issue, 1);
    tick();
    drain();

    // lw x7 then add x8,x7,x0: two bubble cycles then forward from entry 3
    set_dec(1, 1, 1, 0, 0, 7, 1, 1);
    tick();
    set_dec(1, 7, 1, 0, 1, 8, 1, 0);
    chk("lu_bubble1", bubble, 1);
    chk("lu_issue1", issue, 0);
    tick();
    chk("lu_bubble2", bubble, 1);
    tick();
    chk("lu_bubble3", bubble, 0);
    chk("lu_fwd_a", fwd_sel_a, 3);
    chk("lu_fwd_b", fwd_sel_b, 0);
    chk("lu_issue", issue, 1);
    tick();
    drain();

    // youngest wins; x0 never matches
    set_dec(1, 0, 0, 0, 0, 9, 1, 0); tick();
    set_dec(1, 0, 0, 0, 0, 9, 1, 0); tick();
    set_dec(1, 9, 1, 0, 0, 13, 1, 0);
    chk("young_fwd_a", fwd_sel_a, 1);
    tick();
    set_dec(1, 0, 0, 0, 0, 0, 1, 0); tick();
    set_dec(1, 0, 1, 0, 1, 14, 1, 0);
    chk("x0_fwd_a", fwd_sel_a, 0);
    tick();
    drain();

    // flush with three valid entries
    set_dec(1, 0, 0, 0, 0, 10, 1, 0); tick();
    set_dec(1, 0, 0, 0, 0, 11, 1, 0); tick();
    set_dec(1, 0, 0, 0, 0, 12, 1, 0); tick();
    flush = 1'b1;
    set_dec(1, 0, 0, 0, 0, 15, 1, 0);
    chk("fl_issue", issue, 0);
    tick();
    flush = 1'b0;
    set_dec(1, 11, 1, 12, 1, 16, 0, 0);
    chk("fl_stage_we", stage_we, 3'b100);
    chk("fl_fwd_a", fwd_sel_a, 3);
    chk("fl_fwd_b", fwd_sel_b, 0);
    tick();
    drain();

    // stall during a load-use bubble
    set_dec(1, 1, 1, 0, 0, 7, 1, 1); tick();
    set_dec(1, 0, 0, 7, 1, 8, 1, 0); tick();
    stall = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("st_hold", dec_hold, 1);
      chk("st_stage_we", stage_we, 3'b010);
      chk("st_issue", issue, 0);
      tick();
    end
    stall = 1'b0;
    #1;
    chk("st_rel_bubble", bubble, 1);
    tick();
    chk("st_done_bubble", bubble, 0);
    chk("st_done_fwd_b", fwd_sel_b, 3);
    chk("st_done_issue", issue, 1);
    tick();
    drain();

    // flush and bubble in the same cycle
    set_dec(1, 1, 1, 0, 0, 7, 1, 1); tick();
    flush = 1'b1;
    set_dec(1, 7, 1, 0, 0, 8, 1, 0);
    chk("fb_bubble", bubble, 1);
    chk("fb_issue", issue, 0);
    tick();
    flush = 1'b0;
    #1;
    chk("fb_stage_we", stage_we, 0);
    chk("fb_after_issue", issue, 1);
    tick();
    drain();

    // flush held under stall lands on the first unstalled edge
    set_dec(1, 0, 0, 0, 0, 20, 1, 0); tick();
    set_dec(1, 0, 0, 0, 0, 21, 1, 0); tick();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    stall = 1'b1; flush = 1'b1;
    tick(); tick();
    chk("sf_frozen", stage_we, 3'b011);
    stall = 1'b0;
    tick();
    flush = 1'b0;
    #1;
    chk("sf_stage_we", stage_we, 3'b100);
    drain();

    // async reset in the middle of a stall
    set_dec(1, 0, 0, 0, 0, 22, 1, 0); tick(); tick();
    stall = 1'b1;
    tick();
    #2 reset = 1'b0;
    #1;
    model_clear();
    chk("ar_stage_we", stage_we, 0);
    chk("ar_issue", issue, 0);
    chk("ar_dec_hold", dec_hold, 1);
    tick();
    stall = 1'b0; reset = 1'b1;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

`ifdef PIPE_HAZARD_PERF_EN
    set_dec(1, 1, 1, 0, 0, 7, 1, 1); tick();
    set_dec(1, 7, 1, 0, 0, 8, 1, 0); tick(); tick(); tick();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    flush = 1'b1; tick();
    flush = 1'b0; #1;
    chk("perf_bubbles", perf_bubbles, 2);
    chk("perf_flushes", perf_flushes, 1);
    set_dec(1, 0, 0, 0, 0, 23, 1, 0); tick();
    #2 reset = 1'b0;
    #1;
    model_clear();
    chk("perf_rst_b", perf_bubbles, 0);
    chk("perf_rst_f", perf_flushes, 0);
    chk("perf_rst_we", stage_we, 0);
    tick();
    reset = 1'b1;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
